// File: rtl/clock_measure_pkg.sv
// Shared types and defaults for the clock half-period measurement block.
// The default constants are also used by the clock divider bench.
package clock_measure_pkg;

    localparam int DEFAULT_WIDTH   = 32;
    localparam int DEFAULT_TIMEOUT = 100_000_000;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer followed by a previous-value flop.
// Flags a change of either polarity on the synchronized level.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic edge_det
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // synchronizer shift chain and previous synchronized level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign q        = r_sync[SYNC_STAGES-1];
    assign edge_det = r_sync[SYNC_STAGES-1] ^ r_prev;

endmodule

// File: rtl/clock_measure.sv
// Measures the half-period of a slow toggling input in clk cycles and
// reports the equivalent divider 'upto', a lock flag and a dead-input pulse.
module clock_measure
    import clock_measure_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = DEFAULT_TIMEOUT,
    parameter int LOCK_TOL    = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    output logic             meas_valid,
    output logic [WIDTH-1:0] half_period,
    output logic [WIDTH-1:0] upto_est,
    output logic             locked,
    output logic             timeout
);

    localparam logic [WIDTH-1:0] TO_VAL  = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] TOL_VAL = WIDTH'(LOCK_TOL);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    state_e           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_cnt, w_cnt_nxt, w_cnt_inc, w_diff;
    logic [WIDTH-1:0] r_half, w_half_nxt, r_upto, w_upto_nxt;
    logic             r_valid, w_valid_nxt, r_locked, w_locked_nxt;
    logic             r_timeout, w_timeout_nxt, r_first, w_first_nxt;
    logic             w_edge, w_unused_sync_q;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .d       (sig_in),
        .q       (w_unused_sync_q),
        .edge_det(w_edge)
    );

    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + ONE;
    assign w_diff    = (r_cnt >= r_half) ? (r_cnt - r_half) : (r_half - r_cnt);

    // next-state, counter, capture and lock decisions
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_half_nxt    = r_half;
        w_upto_nxt    = r_upto;
        w_valid_nxt   = 1'b0;
        w_locked_nxt  = r_locked;
        w_timeout_nxt = 1'b0;
        w_first_nxt   = r_first;
        case (r_state)
            IDLE: begin
                if (w_edge) begin
                    w_state_nxt = MEASURE;
                    w_cnt_nxt   = ONE;
                    w_first_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = '0;
                end
            end
            MEASURE: begin
                if (w_edge) begin
                    w_half_nxt  = r_cnt;
                    w_upto_nxt  = r_cnt - ONE;
                    w_valid_nxt = 1'b1;
                    w_cnt_nxt   = ONE;
                    w_first_nxt = 1'b0;
                    // stored half-period is meaningless right after re-arming
                    if (r_first) begin
                        w_locked_nxt = 1'b0;
                    end else begin
                        w_locked_nxt = (w_diff <= TOL_VAL);
                    end
                end else if (w_cnt_inc == TO_VAL) begin
                    w_timeout_nxt = 1'b1;
                    w_locked_nxt  = 1'b0;
                    w_state_nxt   = IDLE;
                    w_cnt_nxt     = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // counter, captured measurement and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_half    <= '0;
            r_upto    <= '0;
            r_valid   <= 1'b0;
            r_locked  <= 1'b0;
            r_timeout <= 1'b0;
            r_first   <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_half    <= w_half_nxt;
            r_upto    <= w_upto_nxt;
            r_valid   <= w_valid_nxt;
            r_locked  <= w_locked_nxt;
            r_timeout <= w_timeout_nxt;
            r_first   <= w_first_nxt;
        end
    end

    assign meas_valid  = r_valid;
    assign half_period = r_half;
    assign upto_est    = r_upto;
    assign locked      = r_locked;
    assign timeout     = r_timeout;

endmodule

// File: tb/tb_clock_measure.sv
// Directed bench for clock_measure: table-driven toggle sequences with
// hand-computed half-periods, lock and timeout expectations, plus reset cases.
module tb_clock_measure;

    localparam int TO = 20;

    typedef struct {
        int gap;
        bit exp_valid;
        int exp_hp;
        bit exp_locked;
        bit dead_after;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n, sig0, sig1, sel;
    logic        mv0, lk0, to0, mv1, lk1, to1;
    logic [31:0] hp0, up0, hp1, up1;
    logic        mv_s, lk_s, to_s;
    logic [31:0] hp_s, up_s;
    int          n_cmp  = 0;
    int          n_fail = 0;
    vec_t        tbl[$];

    clock_measure #(.WIDTH(32), .SYNC_STAGES(2), .TIMEOUT(TO), .LOCK_TOL(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .sig_in(sig0), .meas_valid(mv0),
        .half_period(hp0), .upto_est(up0), .locked(lk0), .timeout(to0)
    );

    clock_measure #(.WIDTH(32), .SYNC_STAGES(2), .TIMEOUT(TO), .LOCK_TOL(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .sig_in(sig1), .meas_valid(mv1),
        .half_period(hp1), .upto_est(up1), .locked(lk1), .timeout(to1)
    );

    always #5 clk = ~clk;

    always_comb begin
        mv_s = sel ? mv1 : mv0;
        lk_s = sel ? lk1 : lk0;
        to_s = sel ? to1 : to0;
        hp_s = sel ? hp1 : hp0;
        up_s = sel ? up1 : up0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t v(input int gap, input bit ev, input int hp, input bit lk, input bit dead);
        vec_t r;
        r.gap = gap; r.exp_valid = ev; r.exp_hp = hp; r.exp_locked = lk; r.dead_after = dead;
        return r;
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_hp"}, hp_s, 32'd0);
        chk({tag, "_upto"}, up_s, 32'd0);
        chk({tag, "_locked"}, 32'(lk_s), 32'd0);
        chk({tag, "_valid"}, 32'(mv_s), 32'd0);
        chk({tag, "_timeout"}, 32'(to_s), 32'd0);
    endtask

    // Toggle the selected input after each record's gap (in posedges); the
    // measurement for a toggle at posedge T is visible after posedge T+3.
    task automatic run_table(input bit s);
        int n;
        int t;
        int k_tog;
        int k_chk;
        int last_hp;
        int end_cyc;
        bit exp_to;
        int tog_at[$];
        n = tbl.size();
        t = 0; k_tog = 0; k_chk = 0; last_hp = 0;
        sel = s;
        for (int i = 0; i < n; i++) begin
            t += tbl[i].gap;
            tog_at.push_back(t);
        end
        end_cyc = tog_at[n-1] + (tbl[n-1].dead_after ? TO + 6 : 4);
        for (int c = 1; c <= end_cyc; c++) begin
            @(posedge clk);
            #1;
            if (k_tog < n && c == tog_at[k_tog]) begin
                if (s) sig1 = ~sig1; else sig0 = ~sig0;
                k_tog++;
            end
            @(negedge clk);
            exp_to = 1'b0;
            for (int i = 0; i < n; i++) begin
                if (tbl[i].dead_after && c == tog_at[i] + TO + 2) exp_to = 1'b1;
            end
            chk("timeout", 32'(to_s), 32'(exp_to));
            if (exp_to) begin
                chk("timeout_locked", 32'(lk_s), 32'd0);
                chk("timeout_hp_kept", hp_s, 32'(last_hp));
            end
            if (k_chk < n && c == tog_at[k_chk] + 3) begin
                chk("meas_valid", 32'(mv_s), 32'(tbl[k_chk].exp_valid));
                if (tbl[k_chk].exp_valid) begin
                    chk("half_period", hp_s, 32'(tbl[k_chk].exp_hp));
                    chk("upto_est", up_s, 32'(tbl[k_chk].exp_hp - 1));
                    chk("locked", 32'(lk_s), 32'(tbl[k_chk].exp_locked));
                    last_hp = tbl[k_chk].exp_hp;
                end
                k_chk++;
            end else begin
                chk("no_valid", 32'(mv_s), 32'd0);
            end
        end
    endtask

    initial begin
        rst_n = 1'b1; sig0 = 1'b0; sig1 = 1'b0; sel = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        sel = 1'b0; #0 check_zero("rst0");
        sel = 1'b1; #0 check_zero("rst1");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // upto=4, then upto=9, then upto=0, upto=1, dead input, re-arm
        tbl.delete();
        tbl.push_back(v(3, 1'b0, 0, 1'b0, 1'b0));
        tbl.push_back(v(5, 1'b1, 5, 1'b0, 1'b0));
        tbl.push_back(v(5, 1'b1, 5, 1'b1, 1'b0));
        tbl.push_back(v(5, 1'b1, 5, 1'b1, 1'b0));
        tbl.push_back(v(10, 1'b1, 10, 1'b0, 1'b0));
        tbl.push_back(v(10, 1'b1, 10, 1'b1, 1'b0));
        tbl.push_back(v(1, 1'b1, 1, 1'b0, 1'b0));
        tbl.push_back(v(1, 1'b1, 1, 1'b1, 1'b0));
        tbl.push_back(v(1, 1'b1, 1, 1'b1, 1'b0));
        tbl.push_back(v(2, 1'b1, 2, 1'b0, 1'b1));
        tbl.push_back(v(30, 1'b0, 0, 1'b0, 1'b0));
        tbl.push_back(v(4, 1'b1, 4, 1'b0, 1'b0));
        run_table(1'b0);

        // tolerance of one cycle: 7/8 stays locked, 7/9 drops lock
        tbl.delete();
        tbl.push_back(v(3, 1'b0, 0, 1'b0, 1'b0));
        tbl.push_back(v(7, 1'b1, 7, 1'b0, 1'b0));
        tbl.push_back(v(8, 1'b1, 8, 1'b1, 1'b0));
        tbl.push_back(v(7, 1'b1, 7, 1'b1, 1'b0));
        tbl.push_back(v(8, 1'b1, 8, 1'b1, 1'b0));
        tbl.push_back(v(7, 1'b1, 7, 1'b1, 1'b0));
        tbl.push_back(v(9, 1'b1, 9, 1'b0, 1'b0));
        tbl.push_back(v(7, 1'b1, 7, 1'b0, 1'b0));
        tbl.push_back(v(9, 1'b1, 9, 1'b0, 1'b0));
        tbl.push_back(v(8, 1'b1, 8, 1'b1, 1'b0));
        run_table(1'b1);

        // lock up, then asynchronous reset in the middle of a count
        tbl.delete();
        tbl.push_back(v(3, 1'b0, 0, 1'b0, 1'b0));
        tbl.push_back(v(5, 1'b1, 5, 1'b0, 1'b0));
        tbl.push_back(v(5, 1'b1, 5, 1'b1, 1'b0));
        run_table(1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        sig0  = 1'b0;
        #1 check_zero("async_rst");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        tbl.delete();
        tbl.push_back(v(3, 1'b0, 0, 1'b0, 1'b0));
        tbl.push_back(v(6, 1'b1, 6, 1'b0, 1'b0));
        tbl.push_back(v(6, 1'b1, 6, 1'b1, 1'b0));
        run_table(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
